// File: rtl/fringe_clk_edge_sched.sv
// fringe_clk_edge_sched
//   Scheduling stage in front of the initiator hub. Mission clocks are sampled
//   on the utility clock and their rising edges are detected. Each edge records
//   one pending exchange per (clock, partition) pair enabled in the topology
//   map. Pending exchanges are offered to each partition's get engine over a
//   valid/ready handshake. The mission clock generator is frozen while any
//   exchange is pending.
//
//   Optional feature: define FRNG_SCHED_OVERRUN_CNT_EN to build a saturating
//   8-bit overrun event counter. When it is not defined, overrun_cnt_o is 0.
//
// Ports
//   clk_i          utility clock; all state updates on its rising edge
//   rst_i          asynchronous active-high reset
//   mclk_i         mission clock levels, sampled directly (no synchronizer)
//   map_i          topology; bit c*N_PARTS+p enables clock c -> partition p
//   req_valid_o    per-partition request valid
//   req_clk_o      clock index offered to partition p, in slice p
//   req_ready_i    per-partition accept from the hub
//   freeze_clk_o   high while any exchange is pending
//   overrun_o      sticky; an edge arrived on a pair that was already pending
//   overrun_cnt_o  saturating overrun event count, or 0 when not built
module fringe_clk_edge_sched #(
  parameter int unsigned N_CLOCKS = 13,
  parameter int unsigned N_PARTS  = 4,
  parameter int unsigned CLK_W    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_CLOCKS-1:0]         mclk_i,
  input  logic [N_CLOCKS*N_PARTS-1:0] map_i,
  output logic [N_PARTS-1:0]          req_valid_o,
  output logic [N_PARTS*CLK_W-1:0]    req_clk_o,
  input  logic [N_PARTS-1:0]          req_ready_i,
  output logic                        freeze_clk_o,
  output logic                        overrun_o,
  output logic [7:0]                  overrun_cnt_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_CLOCKS-1:0]               mclk_q;
  logic [N_CLOCKS-1:0]               rise;
  logic [N_CLOCKS-1:0][N_PARTS-1:0]  map;
  logic [N_CLOCKS-1:0][N_PARTS-1:0]  pend_q;
  logic [N_CLOCKS-1:0][N_PARTS-1:0]  pend_d;
  logic [N_CLOCKS-1:0][N_PARTS-1:0]  ovr_evt;
  logic [N_PARTS-1:0][N_CLOCKS-1:0]  col;
  logic [N_PARTS-1:0][CLK_W-1:0]     sel_q;
  logic [N_PARTS-1:0][CLK_W-1:0]     last_q;
  logic [N_PARTS-1:0][CLK_W-1:0]     pick_idx;
  logic [N_PARTS-1:0]                pick_hit;
  logic [N_PARTS-1:0]                accept;
  state_t                            state_q [N_PARTS];
  state_t                            state_d [N_PARTS];

  // The flat map vector has the same bit layout as the packed [c][p] view.
  assign map       = map_i;
  assign rise      = mclk_i & ~mclk_q;
  assign req_clk_o = sel_q;

  // Round-robin search. It starts one past the last accepted index and wraps
  // modulo N_CLOCKS. Returns {found, index}.
  function automatic logic [CLK_W:0] rr_pick(input logic [N_CLOCKS-1:0] pend_col,
                                             input logic [CLK_W-1:0]    last);
    logic             found;
    logic [CLK_W-1:0] idx;
    logic [CLK_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N_CLOCKS; off++) begin
      cand = CLK_W'((32'(last) + off) % N_CLOCKS);
      if (!found && pend_col[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    accept   = '0;
    col      = '0;
    pick_hit = '0;
    pick_idx = '0;
    for (int unsigned p = 0; p < N_PARTS; p++) begin
      accept[p] = (state_q[p] == OFFER) && req_ready_i[p];
      for (int unsigned c = 0; c < N_CLOCKS; c++) begin
        col[p][c] = pend_q[c][p];
      end
      {pick_hit[p], pick_idx[p]} = rr_pick(col[p], last_q[p]);
    end
  end

  // If a new edge and an accept hit the same pair in one cycle, the new edge
  // wins. The pair stays pending and no overrun is counted.
  always_comb begin
    pend_d  = pend_q;
    ovr_evt = '0;
    for (int unsigned c = 0; c < N_CLOCKS; c++) begin
      for (int unsigned p = 0; p < N_PARTS; p++) begin
        ovr_evt[c][p] = rise[c] & map[c][p] & pend_q[c][p] &
                        ~(accept[p] && (sel_q[p] == CLK_W'(c)));
        if (rise[c] && map[c][p]) begin
          pend_d[c][p] = 1'b1;
        end else if (accept[p] && (sel_q[p] == CLK_W'(c))) begin
          pend_d[c][p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mclk_q       <= '0;
      pend_q       <= '0;
      freeze_clk_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      mclk_q       <= mclk_i;
      pend_q       <= pend_d;
      freeze_clk_o <= |pend_d;
      if (|ovr_evt) begin
        overrun_o <= 1'b1;
      end
    end
  end

  // Per-partition handshake FSM. Valid is a pure decode of OFFER, so an
  // asynchronous reset drops it immediately.
  always_comb begin
    req_valid_o = '0;
    for (int unsigned p = 0; p < N_PARTS; p++) begin
      state_d[p]     = state_q[p];
      req_valid_o[p] = (state_q[p] == OFFER);
      case (state_q[p])
        IDLE:    if (pick_hit[p])       state_d[p] = OFFER;
        OFFER:   if (req_ready_i[p])    state_d[p] = IDLE;
        default:                        state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < N_PARTS; p++) begin
        state_q[p] <= IDLE;
        sel_q[p]   <= '0;
        last_q[p]  <= CLK_W'(N_CLOCKS - 1);
      end
    end else begin
      for (int unsigned p = 0; p < N_PARTS; p++) begin
        state_q[p] <= state_d[p];
        if ((state_q[p] == IDLE) && pick_hit[p]) begin
          sel_q[p] <= pick_idx[p];
        end
        if (accept[p]) begin
          last_q[p] <= sel_q[p];
        end
      end
    end
  end

`ifdef FRNG_SCHED_OVERRUN_CNT_EN
  logic [7:0] cnt_q;
  logic [8:0] cnt_sum;

  // Worst case is the current count plus N_CLOCKS*N_PARTS events. That fits in
  // 9 bits at the default sizes, before saturating to 255.
  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int unsigned c = 0; c < N_CLOCKS; c++) begin
      for (int unsigned p = 0; p < N_PARTS; p++) begin
        cnt_sum = cnt_sum + 9'(ovr_evt[c][p]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= (cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0];
    end
  end

  assign overrun_cnt_o = cnt_q;
`else
  assign overrun_cnt_o = '0;
`endif

endmodule

// File: doc/fringe_clk_edge_sched.md
# fringe_clk_edge_sched

Upstream scheduling stage for the initiator hub. Samples the mission clocks on the utility clock, detects rising edges, records one pending exchange per (clock, partition) pair according to a static topology map, and offers the pending exchanges to the hub's per-partition get engines over a valid/ready handshake. While any exchange is outstanding it holds `freeze_clk_o` high so the mission clock generator stalls until the data exchange completes.

## Interface
Parameters:
- `N_CLOCKS`, 13, number of mission clocks; clock index = `all_mission_clocks` enum value.
- `N_PARTS`, 4, number of partitions/sockets; index = `block` enum value.
- `CLK_W`, 4, width of a clock index; must satisfy 2**CLK_W >= N_CLOCKS.

Ports:
- `clk_i` in 1 utility clock; all logic on its rising edge.
- `rst_i` in 1 asynchronous, active-high reset.
- `mclk_i` in N_CLOCKS mission clock levels; asynchronous to `clk_i`, sampled directly with no synchronizer.
- `map_i` in N_CLOCKS*N_PARTS topology; bit `c*N_PARTS+p` = clock c exchanges with partition p; quasi-static.
- `req_valid_o` out N_PARTS per-partition request valid.
- `req_clk_o` out N_PARTS*CLK_W clock index offered to partition p in slice p.
- `req_ready_i` in N_PARTS per-partition accept from hub.
- `freeze_clk_o` out 1 high while any exchange is pending.
- `overrun_o` out 1 sticky: edge arrived on an already-pending pair.
- `overrun_cnt_o` out 8 overrun count (see Configuration).

## Operation
- Edge detect: `mclk_q <= mclk_i`; `rise = mclk_i & ~mclk_q`.
- Pending matrix `pend[c][p]`, N_CLOCKS x N_PARTS bits. Next-state per bit: set if `rise[c] & map_i[c*N_PARTS+p]`; else cleared if accepted this cycle; else held.
- Same-cycle set and accept on one bit: set wins, bit stays 1, no overrun.
- Overrun: `rise[c] & map bit & pend[c][p]` and not accepted this cycle -> `overrun_o` <= 1, held until reset. The pending bit stays 1 and the edge is lost.
- Per-partition FSM, states IDLE and OFFER:
  - IDLE: if any `pend[*][p]`, select via round-robin starting at `last[p]+1` mod N_CLOCKS. Register the selected index into `req_clk_o[p]`, set `req_valid_o[p]`, go to OFFER.
  - OFFER: `req_valid_o[p]` = 1 and `req_clk_o[p]` stable until `req_ready_i[p]`. On accept, clear `pend[sel][p]`, set `last[p] <= sel`, drop valid, return to IDLE.
  - Minimum of one IDLE bubble between consecutive requests of the same partition.
- A map bit cleared while its pair is pending does not cancel it; the offer still completes.
- `freeze_clk_o <= |pend_next`, registered.
- Partitions are fully independent; all N_PARTS may accept in the same cycle.

## Timing
- Reset values: `req_valid_o` 0, `req_clk_o` 0, `freeze_clk_o` 0, `overrun_o` 0, `overrun_cnt_o` 0. `mclk_q` 0 and `pend` 0, so a clock that is high out of reset registers an edge on the first cycle. `last[p]` = N_CLOCKS-1, so index 0 has first priority.
- Rising edge of `mclk_i` present before clk edge k:
  - `pend` set at edge k.
  - `freeze_clk_o` high after edge k.
  - `req_valid_o` high after edge k+1.
- Ready sampled at edge j while valid:
  - `pend` bit clear after edge j.
  - `freeze_clk_o` low after edge j if this was the last pending bit.
- Reset mid-handshake: valid drops immediately (async), all pending exchanges are discarded, FSMs return to IDLE.

## Configuration
- `FRNG_SCHED_OVERRUN_CNT_EN` defined: `overrun_cnt_o` is an 8-bit counter, +1 per overrun event. Simultaneous events on several pairs in one cycle add their popcount. The counter saturates at 255.
- Not defined: `overrun_cnt_o` tied to 0; `overrun_o` behaviour unchanged.

## Test plan
- Reset release with `mclk_i`=0, map = clk6/7/8/11 -> TARGET (p=2) only; rise on `mclk_i[6]` -> `freeze_clk_o`=1 one cycle later, `req_valid_o[2]`=1 with `req_clk_o[2]`=6 two cycles later; ready=1 for one cycle -> `freeze_clk_o`=0 next cycle.
- Simultaneous rises on clocks 6, 7, 11 with `req_ready_i[2]` tied 1 -> TARGET offered 6, 7, 11 in order, one request every 2 cycles, then `freeze_clk_o`=0.
- clk9 mapped to part0 and part3, single rise -> `req_valid_o[0]` and `req_valid_o[3]` both high with index 9 in the same cycle; ready on p0 only -> `freeze_clk_o` stays 1 until p3 accepts.
- Rise on clk6 while `pend[6][2]` set and ready held 0 -> `overrun_o`=1; `overrun_cnt_o`=1 with macro, 0 without. A second rise coincident with accept -> bit re-pended, no overrun increment.
- Assert `rst_i` during OFFER -> `req_valid_o`=0 and `freeze_clk_o`=0 immediately; after release, no request is issued until a new edge arrives.
- Round-robin check: after 11 is accepted with 6 and 7 re-pended -> next offer is 6, not 7 from a stale pointer.
